branch_predictor: RTL and testbench

- Parametrised branch prediction unit for the 5-stage RISC-V pipeline.
- Replaces the external pre_branch/prediction/label/error/correct/new_label stimulus with an internal BTB plus a pattern history table (PHT) of saturating counters.
- Optional gshare global-history indexing.
- IF-stage lookup keyed on pc; M-stage resolution keyed on pc_M produces the flush/redirect signals consumed by the IF/ID register and the PC mux.

---
 rtl/bp_pkg.sv | 41 ++++
 rtl/bp_sat_counter_table.sv | 50 +++++
 rtl/branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_branch_predictor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter helpers and pc field extraction.
// Helpers operate on maximum-width vectors; callers slice to their parametrised widths.
package bp_pkg;

    localparam int CTR_MAX_BITS = 3;
    localparam int IDX_MAX_BITS = 10;
    localparam int TAG_MAX_BITS = 32;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    // Weakly-not-taken reset value: 2^(bits-1)-1, which is 0 for a 1-bit counter.
    function automatic ctr_t ctr_weak_nt(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t ctr_max(input int bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c, input int bits);
        return (c == ctr_max(bits)) ? c : c + 1'b1;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c, input int bits);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [IDX_MAX_BITS-1:0] idx_of(input logic [63:0] pc, input int idx_bits);
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return IDX_MAX_BITS'((pc >> 2) & mask);
    endfunction

    function automatic logic [TAG_MAX_BITS-1:0] tag_of(input logic [63:0] pc, input int idx_bits,
                                                      input int tag_bits);
        logic [63:0] mask;
        mask = (64'd1 << tag_bits) - 64'd1;
        return TAG_MAX_BITS'((pc >> (idx_bits + 2)) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: saturating counters with one read port and one
// read-modify-write update port; every counter resets to weakly-not-taken.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_ctr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_taken
);

    localparam ctr_t CTR_WEAK_NT = ctr_weak_nt(CW);

    logic [CW-1:0] ctr_q [DEPTH];
    logic [CW-1:0] ctr_d [DEPTH];
    ctr_t          cur_ext;
    ctr_t          nxt_ext;
    logic          unused_ctr;

    assign rd_ctr     = ctr_q[rd_addr];
    assign unused_ctr = ^nxt_ext;

    always_comb begin
        ctr_d              = ctr_q;
        cur_ext            = '0;
        cur_ext[CW-1:0]    = ctr_q[wr_addr];
        nxt_ext            = wr_taken ? sat_inc(cur_ext, CW) : sat_dec(cur_ext, CW);
        if (wr_en) begin
            ctr_d[wr_addr] = nxt_ext[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_WEAK_NT[CW-1:0];
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction unit: direct-mapped BTB plus PHT of saturating counters,
// bimodal or gshare indexed; IF-stage lookup and M-stage resolution/update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 64,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0,
    parameter int STAT_BITS  = 16,
    localparam int IDX       = $clog2(ENTRIES),
    localparam int HW        = (HIST_BITS == 0) ? 1 : HIST_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pre_branch,
    output logic                  prediction,
    output logic [DATA_WIDTH-1:0] label,
    // upd_valid is a one-cycle strobe with no back-pressure: each high cycle
    // consumes exactly one resolved branch described by the other upd_* inputs.
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] pc_M,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [DATA_WIDTH-1:0] upd_pred_label,
    input  logic [HW-1:0]         upd_hist,
    output logic [HW-1:0]         ghr,
    output logic                  error,
    output logic                  correct,
    output logic [DATA_WIDTH-1:0] new_label,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_mispredicts
);

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_WIDTH-1:0] target;
    } btb_entry_t;

    btb_entry_t                btb_q [ENTRIES];
    btb_entry_t                btb_d [ENTRIES];
    logic [HW-1:0]             ghr_q, ghr_d, ghr_shift;
    logic [STAT_BITS-1:0]      br_q, br_d, mp_q, mp_d;
    logic [63:0]               pc_ext, pcm_ext;
    logic [IDX_MAX_BITS-1:0]   lk_idx_full, up_idx_full;
    logic [TAG_MAX_BITS-1:0]   lk_tag_full, up_tag_full;
    logic [IDX-1:0]            lk_idx, up_idx, lk_hist, up_hist_ext, lk_pidx, up_pidx;
    logic [TAG_BITS-1:0]       lk_tag, up_tag;
    btb_entry_t                lk_entry;
    logic [CTR_BITS-1:0]       lk_ctr;
    logic                      mispredict;
    logic                      unused_bits;

    assign unused_bits = ^{lk_idx_full, up_idx_full, lk_tag_full, up_tag_full, upd_hist};

    always_comb begin
        pc_ext                    = '0;
        pc_ext[DATA_WIDTH-1:0]    = pc;
        pcm_ext                   = '0;
        pcm_ext[DATA_WIDTH-1:0]   = pc_M;
        lk_idx_full               = idx_of(pc_ext, IDX);
        up_idx_full               = idx_of(pcm_ext, IDX);
        lk_tag_full               = tag_of(pc_ext, IDX, TAG_BITS);
        up_tag_full               = tag_of(pcm_ext, IDX, TAG_BITS);
        lk_idx                    = lk_idx_full[IDX-1:0];
        up_idx                    = up_idx_full[IDX-1:0];
        lk_tag                    = lk_tag_full[TAG_BITS-1:0];
        up_tag                    = up_tag_full[TAG_BITS-1:0];
        lk_hist                   = '0;
        up_hist_ext               = '0;
        // The update side uses the piped snapshot so it trains the counter the lookup read.
        if (HIST_BITS > 0) begin
            lk_hist[HW-1:0]       = ghr_q;
            up_hist_ext[HW-1:0]   = upd_hist;
        end
        lk_pidx                   = lk_idx ^ lk_hist;
        up_pidx                   = up_idx ^ up_hist_ext;
    end

    bp_sat_counter_table #(
        .DEPTH (ENTRIES),
        .AW    (IDX),
        .CW    (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (lk_pidx),
        .rd_ctr   (lk_ctr),
        .wr_en    (upd_valid),
        .wr_addr  (up_pidx),
        .wr_taken (upd_taken)
    );

    always_comb begin
        lk_entry   = btb_q[lk_idx];
        pre_branch = lk_entry.valid && (lk_entry.tag == lk_tag);
        prediction = pre_branch && lk_ctr[CTR_BITS-1];
        label      = pre_branch ? lk_entry.target : pc + DATA_WIDTH'(4);
    end

    assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                      (upd_taken && (upd_pred_label != upd_target)));
    assign error      = mispredict;
    assign correct    = upd_valid && !mispredict;
    assign new_label  = upd_taken ? upd_target : pc_M + DATA_WIDTH'(4);

    generate
        if (HIST_BITS > 1) begin : g_hist_shift
            assign ghr_shift = {ghr_q[HW-2:0], upd_taken};
        end else begin : g_hist_bit
            assign ghr_shift = upd_taken;
        end
    endgenerate

    always_comb begin
        btb_d = btb_q;
        ghr_d = ghr_q;
        br_d  = br_q;
        mp_d  = mp_q;
        if (upd_valid) begin
            if (upd_taken) begin
                btb_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target};
            end
            if (HIST_BITS > 0) begin
                ghr_d = ghr_shift;
            end
            if (br_q != '1) begin
                br_d = br_q + 1'b1;
            end
            if (mispredict && (mp_q != '1)) begin
                mp_d = mp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
            ghr_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            btb_q <= btb_d;
            ghr_q <= ghr_d;
            br_q  <= br_d;
            mp_q  <= mp_d;
        end
    end

    assign ghr              = ghr_q;
    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare (HIST_BITS=4) instance share
// the stimulus and are both checked against an array-based model of the predictor.
module tb_branch_predictor;

    localparam int N  = 64;
    localparam int HB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_m, upd_target;
    logic        upd_valid, upd_taken;
    logic        pt0, pt1;
    logic [31:0] pl0, pl1;
    logic        h0;
    logic [3:0]  h1;

    logic        pb0, pr0, er0, co0, g0;
    logic [31:0] lb0, nl0;
    logic [15:0] sb0, sm0;
    logic        pb1, pr1, er1, co1;
    logic [3:0]  g1;
    logic [31:0] lb1, nl1;
    logic [15:0] sb1, sm1;

    always #5 clk = ~clk;

    branch_predictor #(.HIST_BITS(0)) u_bim (
        .clk(clk), .rst(rst), .pc(pc), .pre_branch(pb0), .prediction(pr0), .label(lb0),
        .upd_valid(upd_valid), .pc_M(pc_m), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(pt0), .upd_pred_label(pl0), .upd_hist(h0), .ghr(g0),
        .error(er0), .correct(co0), .new_label(nl0),
        .stat_branches(sb0), .stat_mispredicts(sm0)
    );

    branch_predictor #(.HIST_BITS(HB)) u_gsh (
        .clk(clk), .rst(rst), .pc(pc), .pre_branch(pb1), .prediction(pr1), .label(lb1),
        .upd_valid(upd_valid), .pc_M(pc_m), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(pt1), .upd_pred_label(pl1), .upd_hist(h1), .ghr(g1),
        .error(er1), .correct(co1), .new_label(nl1),
        .stat_branches(sb1), .stat_mispredicts(sm1)
    );

    // Reference model: [0] = bimodal instance, [1] = gshare instance.
    bit          m_valid [2][N];
    int unsigned m_tag   [2][N];
    logic [31:0] m_tgt   [2][N];
    int          m_pht   [2][N];
    int unsigned m_ghr   [2];
    int unsigned m_sb    [2];
    int unsigned m_sm    [2];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned bidx(input logic [31:0] a);
        return (a / 4) % N;
    endfunction

    function automatic int unsigned btag(input logic [31:0] a);
        return (a / (4 * N)) % 256;
    endfunction

    function automatic bit m_hit(input int m, input logic [31:0] a);
        return m_valid[m][bidx(a)] && (m_tag[m][bidx(a)] == btag(a));
    endfunction

    function automatic bit m_pred(input int m, input logic [31:0] a);
        return m_hit(m, a) && (m_pht[m][bidx(a) ^ m_ghr[m]] >= 2);
    endfunction

    function automatic logic [31:0] m_label(input int m, input logic [31:0] a);
        return m_hit(m, a) ? m_tgt[m][bidx(a)] : a + 32'd4;
    endfunction

    function automatic void m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                m_valid[m][i] = 1'b0;
                m_pht[m][i]   = 1;
            end
            m_ghr[m] = 0;
            m_sb[m]  = 0;
            m_sm[m]  = 0;
        end
    endfunction

    function automatic void m_update(input int m, input logic [31:0] am, input bit t,
                                     input logic [31:0] tg, input bit mis, input int unsigned hist);
        int unsigned i;
        i = bidx(am) ^ ((m == 1) ? hist : 0);
        if (t && m_pht[m][i] < 3) m_pht[m][i]++;
        if (!t && m_pht[m][i] > 0) m_pht[m][i]--;
        if (t) begin
            m_valid[m][bidx(am)] = 1'b1;
            m_tag[m][bidx(am)]   = btag(am);
            m_tgt[m][bidx(am)]   = tg;
        end
        m_ghr[m] = (m == 1) ? ((m_ghr[m] * 2 + (t ? 1 : 0)) % 16) : 0;
        if (m_sb[m] < 65535) m_sb[m]++;
        if (mis && m_sm[m] < 65535) m_sm[m]++;
    endfunction

    bit          cur_mis0, cur_mis1, cur_v, cur_t;
    logic [31:0] cur_am, cur_tg;
    int unsigned cur_h1;

    // Drive one cycle of inputs and compare every output of both instances.
    task automatic apply(input logic [31:0] a, input bit v, input logic [31:0] am, input bit t,
                         input logic [31:0] tg, input bit p0, input logic [31:0] l0,
                         input bit p1, input logic [31:0] l1, input logic [3:0] hh1);
        logic [31:0] nlab;
        pc = a; upd_valid = v; pc_m = am; upd_taken = t; upd_target = tg;
        pt0 = p0; pl0 = l0; pt1 = p1; pl1 = l1; h0 = 1'b0; h1 = hh1;
        cur_v = v; cur_t = t; cur_am = am; cur_tg = tg; cur_h1 = hh1;
        cur_mis0 = v && ((p0 != t) || (t && (l0 != tg)));
        cur_mis1 = v && ((p1 != t) || (t && (l1 != tg)));
        nlab = t ? tg : am + 32'd4;
        #1;
        check_eq("pre_branch_bim", pb0, m_hit(0, a));
        check_eq("prediction_bim", pr0, m_pred(0, a));
        check_eq("label_bim", lb0, m_label(0, a));
        check_eq("error_bim", er0, cur_mis0);
        check_eq("correct_bim", co0, v && !cur_mis0);
        check_eq("new_label_bim", nl0, nlab);
        check_eq("ghr_bim", g0, 0);
        check_eq("stat_br_bim", sb0, m_sb[0]);
        check_eq("stat_mp_bim", sm0, m_sm[0]);
        check_eq("pre_branch_gsh", pb1, m_hit(1, a));
        check_eq("prediction_gsh", pr1, m_pred(1, a));
        check_eq("label_gsh", lb1, m_label(1, a));
        check_eq("error_gsh", er1, cur_mis1);
        check_eq("correct_gsh", co1, v && !cur_mis1);
        check_eq("new_label_gsh", nl1, nlab);
        check_eq("ghr_gsh", g1, m_ghr[1]);
        check_eq("stat_br_gsh", sb1, m_sb[1]);
        check_eq("stat_mp_gsh", sm1, m_sm[1]);
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur_v) begin
            m_update(0, cur_am, cur_t, cur_tg, cur_mis0, 0);
            m_update(1, cur_am, cur_t, cur_tg, cur_mis1, cur_h1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] a);
        apply(a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    // Resolve a branch at a with the predictions each instance issues for it this cycle.
    task automatic resolve(input logic [31:0] a, input bit t, input logic [31:0] tg);
        apply(a, 1'b1, a, t, tg, m_pred(0, a), m_label(0, a), m_pred(1, a), m_label(1, a),
              4'(m_ghr[1]));
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'(256 * $urandom_range(0, 2));
    endfunction

    int alt_err0, alt_err1;

    initial begin
        rst = 1'b0;
        pc = 32'h0; pc_m = 32'h0; upd_valid = 1'b0; upd_taken = 1'b0; upd_target = 32'h0;
        pt0 = 1'b0; pt1 = 1'b0; pl0 = 32'h0; pl1 = 32'h0; h0 = 1'b0; h1 = 4'h0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state seen through a lookup of 0x40.
        idle(32'h40);
        check_eq("rst_pre_branch", pb0, 0);
        check_eq("rst_prediction", pr0, 0);
        check_eq("rst_label", lb0, 32'h44);
        check_eq("rst_stat_br", sb0, 0);
        check_eq("rst_stat_mp", sm0, 0);
        advance();

        // First taken resolution allocates and mispredicts.
        apply(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b0, 32'h44, 4'h0);
        check_eq("alloc_error", er0, 1);
        check_eq("alloc_new_label", nl0, 32'h80);
        advance();
        idle(32'h40);
        check_eq("alloc_stat_mp", sm0, 1);
        check_eq("alloc_pre_branch", pb0, 1);
        check_eq("alloc_prediction", pr0, 1);
        check_eq("alloc_label", lb0, 32'h80);
        advance();

        // Train to 11, then four not-taken resolutions saturate at 00.
        resolve(32'h40, 1'b1, 32'h80);
        advance();
        for (int k = 0; k < 4; k++) begin
            apply(32'h40, 1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44,
                  m_pred(1, 32'h40), m_label(1, 32'h40), 4'(m_ghr[1]));
            check_eq("nt_correct", co0, 1);
            advance();
        end
        idle(32'h40);
        check_eq("sat_pre_branch", pb0, 1);
        check_eq("sat_prediction", pr0, 0);
        advance();

        // Aliasing: 0x40 + 4*N shares the index but not the tag.
        idle(32'h140);
        check_eq("alias_miss", pb0, 0);
        advance();
        resolve(32'h140, 1'b1, 32'h300);
        advance();
        idle(32'h40);
        check_eq("alias_evicted", pb0, 0);
        advance();
        idle(32'h140);
        check_eq("alias_hit", pb0, 1);
        advance();

        // Alternating T/NT: gshare learns it, bimodal mispredicts every time.
        alt_err0 = 0;
        alt_err1 = 0;
        for (int k = 0; k < 40; k++) begin
            resolve(32'h200, (k % 2) == 0, 32'h400);
            if (k >= 24) begin
                alt_err0 += int'(er0);
                alt_err1 += int'(er1);
            end
            advance();
        end
        check_eq("gshare_alt_errors", alt_err1, 0);
        check_eq("bimodal_alt_errors", alt_err0, 16);

        // Same-cycle lookup and update to one index sees the old entry.
        resolve(32'h7c0, 1'b1, 32'h900);
        check_eq("same_cycle_pre_branch", pb0, 0);
        check_eq("same_cycle_label", lb0, 32'h7c4);
        advance();
        idle(32'h7c0);
        check_eq("next_cycle_pre_branch", pb0, 1);
        check_eq("next_cycle_label", lb0, 32'h900);
        advance();

        // Randomised traffic, mostly with correctly piped predictions.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, am, tg, l0, l1;
            bit v, t, p0, p1;
            logic [3:0] hh;
            a  = rand_pc();
            am = rand_pc();
            tg = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            t  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) != 0) begin
                p0 = m_pred(0, am); l0 = m_label(0, am);
                p1 = m_pred(1, am); l1 = m_label(1, am);
                hh = 4'(m_ghr[1]);
            end else begin
                p0 = $urandom_range(0, 1) == 1;
                p1 = $urandom_range(0, 1) == 1;
                l0 = ($urandom_range(0, 1) == 1) ? tg : am + 32'd4;
                l1 = ($urandom_range(0, 1) == 1) ? tg : $urandom;
                hh = 4'($urandom_range(0, 15));
            end
            apply(a, v, am, t, tg, p0, l0, p1, l1, hh);
            advance();
        end

        // Asynchronous reset mid-stream.
        resolve(32'h1004, 1'b1, 32'h2000);
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
        rst = 1'b0;
        m_reset();
        #1;
        check_eq("midrst_pre_branch", pb0, 0);
        check_eq("midrst_ghr", g1, 0);
        check_eq("midrst_stat_br", sb1, 0);
        check_eq("midrst_stat_mp", sm0, 0);
        @(negedge clk);
        rst = 1'b1;
        cur_v = 1'b0;
        idle(32'h40);
        check_eq("post_rst_0x40", pb0, 0);
        advance();
        idle(32'h200);
        check_eq("post_rst_0x200_gsh", pb1, 0);
        advance();
        resolve(32'h200, 1'b1, 32'h400);
        advance();
        idle(32'h200);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
